// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : N:1 registered data multiplexer with valid/ready handshake.
//               Winner chosen by manual index, fixed priority (lowest index)
//               or round-robin, selected at runtime via mode. The winning
//               word is captured into a one-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  localparam logic [1:0] C_MODE_MANUAL = 2'b00;
  localparam logic [1:0] C_MODE_FIXED  = 2'b01;
  localparam logic [1:0] C_MODE_RR     = 2'b10;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic              w_load_en;
  logic              w_grant_valid;
  logic [SEL_W-1:0]  w_grant;
  logic [DATA_W-1:0] w_grant_data;
  logic [SEL_W-1:0]  w_rr_next;
  logic [DATA_W-1:0] w_ch_data [NUM_CH];

  // Split the flat input bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign w_ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The output slot can take a word when it is empty or being drained now.
  assign w_load_en = ~r_out_valid | out_ready;

  // Pick the winning channel for the current mode.
  always_comb begin
    int idx;
    w_grant_valid = 1'b0;
    w_grant       = '0;
    idx           = 0;
    case (mode)
      C_MODE_MANUAL: begin
        // Loop-based match also rejects sel values >= NUM_CH.
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel == SEL_W'(i) && in_valid[i]) begin
            w_grant_valid = 1'b1;
            w_grant       = sel;
          end
        end
      end
      C_MODE_FIXED: begin
        // Scan high to low so the lowest valid index is the last to win.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            w_grant_valid = 1'b1;
            w_grant       = SEL_W'(i);
          end
        end
      end
      C_MODE_RR: begin
        // Scan offsets from far to near so the nearest to rr_ptr wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          idx = int'(r_rr_ptr) + k;
          if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
          end
          if (in_valid[idx]) begin
            w_grant_valid = 1'b1;
            w_grant       = SEL_W'(idx);
          end
        end
      end
      default: begin
        w_grant_valid = 1'b0;
      end
    endcase
  end

  // Route the winning channel's word toward the output register.
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_grant_data = w_ch_data[i];
      end
    end
  end

  // Only the granted channel sees ready, and never while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (!rst && w_load_en && w_grant_valid) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  assign w_rr_next = (w_grant == SEL_W'(NUM_CH - 1)) ? '0 : w_grant + SEL_W'(1);

  // Output register and round-robin pointer; both move only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_out_data <= w_grant_data;
        r_out_sel  <= w_grant;
        r_rr_ptr   <= w_rr_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire
